// File: rtl/spi_adi_reg_slave.sv
// SPI register-file responder for 24-bit ADI-style frames (rw, 5 reserved, 10-bit addr, 8-bit data).
// SPI pins are synchronised into clk; the register file is exported flat on regs_flat.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a spi_enb falling edge
// SHIFT   | sampling bits on spi_clk rising edges, driving read data on falling edges
// HOLD    | 24 bits taken, ignoring spi_clk until spi_enb rises
module spi_adi_reg_slave #(
    parameter int REG_NUM = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spi_clk,
    input  logic                 spi_enb,
    input  logic                 spi_di,
    output logic                 spi_do,
    output logic                 wr_valid,
    output logic [9:0]           wr_addr,
    output logic [7:0]           wr_data,
    output logic                 rd_valid,
    output logic [9:0]           rd_addr,
    output logic [REG_NUM*8-1:0] regs_flat,
    output logic                 frame_err
);

    localparam int         AW      = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam logic [10:0] REG_LIM = 11'(REG_NUM);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_HOLD} state_t;

    logic [1:0] clk_sync;
    logic [1:0] enb_sync;
    logic [1:0] di_sync;
    logic       clk_prev;
    logic       enb_prev;

    // Sync flops reset low so a select already held low at reset release never looks like a new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= '0;
            enb_sync <= '0;
            di_sync  <= '0;
            clk_prev <= 1'b0;
            enb_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], spi_clk};
            enb_sync <= {enb_sync[0], spi_enb};
            di_sync  <= {di_sync[0], spi_di};
            clk_prev <= clk_sync[1];
            enb_prev <= enb_sync[1];
        end
    end

    logic clk_rise;
    logic clk_fall;
    logic enb_rise;
    logic enb_fall;
    logic di_s;

    assign clk_rise = clk_sync[1] & ~clk_prev;
    assign clk_fall = ~clk_sync[1] & clk_prev;
    assign enb_rise = enb_sync[1] & ~enb_prev;
    assign enb_fall = ~enb_sync[1] & enb_prev;
    assign di_s     = di_sync[1];

    state_t     state;
    logic [4:0] bit_cnt;
    logic [8:0] shreg;
    logic       rw_bit;
    logic [9:0] cur_addr;
    logic [7:0] rd_byte;
    logic [3:0] rd_cnt;
    logic       commit_pend;
    logic [9:0] commit_addr;
    logic [7:0] commit_data;
    logic [7:0] regs [REG_NUM];

    logic [9:0] addr_new;
    logic       addr_new_ok;
    logic       cur_addr_ok;

    // Only the address and data tails are kept; rw is caught on the first bit, reserved bits fall off.
    assign addr_new    = {shreg, di_s};
    assign addr_new_ok = ({1'b0, addr_new} < REG_LIM);
    assign cur_addr_ok = ({1'b0, cur_addr} < REG_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            rw_bit      <= 1'b0;
            cur_addr    <= '0;
            rd_byte     <= '0;
            rd_cnt      <= '0;
            commit_pend <= 1'b0;
            commit_addr <= '0;
            commit_data <= '0;
            spi_do      <= 1'b0;
            wr_valid    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            rd_valid    <= 1'b0;
            rd_addr     <= '0;
            frame_err   <= 1'b0;
            for (int k = 0; k < REG_NUM; k++) begin
                regs[k] <= '0;
            end
        end else begin
            rd_valid    <= 1'b0;
            wr_valid    <= 1'b0;
            frame_err   <= 1'b0;
            commit_pend <= 1'b0;

            if (commit_pend) begin
                regs[commit_addr[AW-1:0]] <= commit_data;
                wr_valid                  <= 1'b1;
                wr_addr                   <= commit_addr;
                wr_data                   <= commit_data;
            end

            case (state)
                ST_IDLE: begin
                    spi_do <= 1'b0;
                    rd_cnt <= '0;
                    if (enb_fall) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end
                end

                ST_SHIFT: begin
                    if (enb_rise) begin
                        state     <= ST_IDLE;
                        frame_err <= 1'b1;
                        spi_do    <= 1'b0;
                        rd_cnt    <= '0;
                    end else if (clk_rise) begin
                        shreg   <= {shreg[7:0], di_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd0) begin
                            rw_bit <= di_s;
                        end
                        if (bit_cnt == 5'd15) begin
                            cur_addr <= addr_new;
                            if (rw_bit) begin
                                rd_valid <= 1'b1;
                                rd_addr  <= addr_new;
                                rd_byte  <= addr_new_ok ? regs[addr_new[AW-1:0]] : 8'h00;
                                rd_cnt   <= 4'd8;
                            end
                        end
                        if (bit_cnt == 5'd23) begin
                            state  <= ST_HOLD;
                            spi_do <= 1'b0;
                            rd_cnt <= '0;
                            if (!rw_bit && cur_addr_ok) begin
                                commit_pend <= 1'b1;
                                commit_addr <= cur_addr;
                                commit_data <= {shreg[6:0], di_s};
                            end
                        end
                    end else if (clk_fall && rd_cnt != 4'd0) begin
                        spi_do  <= rd_byte[7];
                        rd_byte <= {rd_byte[6:0], 1'b0};
                        rd_cnt  <= rd_cnt - 4'd1;
                    end
                end

                ST_HOLD: begin
                    spi_do <= 1'b0;
                    if (enb_rise) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    spi_do <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < REG_NUM; k++) begin : g_flat
        assign regs_flat[8*k+7:8*k] = regs[k];
    end

endmodule

// File: tb/tb_spi_adi_reg_slave.sv
// Self-checking bench for spi_adi_reg_slave: directed frames from the test plan plus random
// frames, all compared against a frame-level register model.
module tb_spi_adi_reg_slave;

    localparam int REG_NUM = 16;
    localparam int CLK_P   = 10;
    localparam int HALF    = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 spi_clk;
    logic                 spi_enb;
    logic                 spi_di;
    logic                 spi_do;
    logic                 wr_valid;
    logic [9:0]           wr_addr;
    logic [7:0]           wr_data;
    logic                 rd_valid;
    logic [9:0]           rd_addr;
    logic [REG_NUM*8-1:0] regs_flat;
    logic                 frame_err;

    spi_adi_reg_slave #(.REG_NUM(REG_NUM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_clk   (spi_clk),
        .spi_enb   (spi_enb),
        .spi_di    (spi_di),
        .spi_do    (spi_do),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_addr   (rd_addr),
        .regs_flat (regs_flat),
        .frame_err (frame_err)
    );

    always #(CLK_P/2) clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  model_regs [REG_NUM];
    logic [17:0] wr_q[$];
    int          wr_lat_q[$];
    logic [9:0]  rd_q[$];
    int          rd_lat_q[$];
    int          err_seen = 0;
    longint      t_rise16 = 0;
    longint      t_rise24 = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < REG_NUM; k++) v[8*k +: 8] = model_regs[k];
        return v;
    endfunction

    // Monitor samples on the falling clk edge, half a cycle away from DUT updates.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_valid) begin
                wr_q.push_back({wr_addr, wr_data});
                wr_lat_q.push_back(int'(($time - t_rise24) / CLK_P));
            end
            if (rd_valid) begin
                rd_q.push_back(rd_addr);
                rd_lat_q.push_back(int'(($time - t_rise16) / CLK_P));
            end
            if (frame_err) err_seen++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_regs"}, 128'(regs_flat), 128'd0);
        check_val({tag, "_pulses_do"}, 128'({wr_valid, rd_valid, frame_err, spi_do}), 128'd0);
        check_val({tag, "_wr_addr"}, 128'(wr_addr), 128'd0);
        check_val({tag, "_wr_data"}, 128'(wr_data), 128'd0);
        check_val({tag, "_rd_addr"}, 128'(rd_addr), 128'd0);
    endtask

    // One master frame: nbits < 24 aborts early, rst_bit >= 0 pulses reset after that bit's rising edge.
    task automatic run_frame(input logic [23:0] frame, input int nbits, input int gap, input int rst_bit);
        logic       rw;
        logic [9:0] a;
        logic [7:0] d;
        logic [7:0] miso;
        logic [7:0] exp_miso;
        logic       do_bad;
        logic       reset_hit;
        int         err_before;
        int         exp_wr;
        int         exp_rd;
        int         exp_err;
        logic [17:0] wv;

        rw         = frame[23];
        a          = frame[17:8];
        d          = frame[7:0];
        exp_miso   = (int'(a) < REG_NUM) ? model_regs[a[3:0]] : 8'h00;
        miso       = '0;
        do_bad     = 1'b0;
        reset_hit  = 1'b0;
        err_before = err_seen;

        spi_enb = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_di = frame[23-i];
            wait_clk(HALF);
            spi_clk = 1'b1;
            if (i == 15) t_rise16 = $time;
            if (i == 23) t_rise24 = $time;
            if (i >= 16) miso[23-i] = spi_do;
            else if (spi_do !== 1'b0) do_bad = 1'b1;
            if (i == rst_bit) begin
                rst_n = 1'b0;
                wait_clk(1);
                check_reset_outputs("midrst");
                for (int k = 0; k < REG_NUM; k++) model_regs[k] = 8'h00;
                reset_hit = 1'b1;
                wait_clk(2);
                rst_n = 1'b1;
            end
            wait_clk(HALF);
            spi_clk = 1'b0;
        end
        spi_di = 1'b0;
        wait_clk(HALF);
        if (nbits == 24 && spi_do !== 1'b0) do_bad = 1'b1;
        spi_enb = 1'b1;
        wait_clk(gap);
        if (spi_do !== 1'b0) do_bad = 1'b1;

        exp_wr  = (nbits == 24 && !reset_hit && !rw && int'(a) < REG_NUM) ? 1 : 0;
        exp_rd  = (rw && nbits >= 16 && !(reset_hit && rst_bit < 15)) ? 1 : 0;
        exp_err = (nbits < 24 && !reset_hit) ? 1 : 0;

        check_val("wr_count", 128'(wr_q.size()), 128'(exp_wr));
        if (exp_wr == 1 && wr_q.size() > 0) begin
            wv = wr_q.pop_front();
            check_val("wr_addr", 128'(wv[17:8]), 128'(a));
            check_val("wr_data", 128'(wv[7:0]), 128'(d));
            check_val("wr_latency", 128'(wr_lat_q.pop_front()), 128'd4);
            model_regs[a[3:0]] = d;
        end
        check_val("rd_count", 128'(rd_q.size()), 128'(exp_rd));
        if (exp_rd == 1 && rd_q.size() > 0) begin
            check_val("rd_addr", 128'(rd_q.pop_front()), 128'(a));
            check_val("rd_latency", 128'(rd_lat_q.pop_front()), 128'd3);
        end
        if (rw && nbits == 24) check_val("rd_data", 128'(miso), 128'(exp_miso));
        check_val("spi_do_idle", 128'(do_bad), 128'd0);
        check_val("frame_err", 128'(err_seen - err_before), 128'(exp_err));
        check_val("regs_flat", 128'(regs_flat), model_flat());
        wr_q.delete();
        wr_lat_q.delete();
        rd_q.delete();
        rd_lat_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0]  ra;
        logic [23:0] fr;
        int          nb;

        for (int k = 0; k < REG_NUM; k++) model_regs[k] = 8'h00;
        rst_n   = 1'b0;
        spi_clk = 1'b0;
        spi_enb = 1'b1;
        spi_di  = 1'b0;
        wait_clk(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_clk(4);

        run_frame(24'h0005A5, 24, 6, -1);
        run_frame(24'h800500, 24, 6, -1);
        run_frame(24'h03FF3C, 24, 6, -1);
        run_frame(24'h83FF00, 24, 6, -1);
        run_frame(24'h000277, 12, 6, -1);
        run_frame(24'h000277, 24, 6, -1);
        run_frame(24'h800200, 24, 6, -1);
        run_frame(24'h000199, 24, 6, 19);
        run_frame(24'h000355, 24, 6, -1);
        run_frame(24'h800300, 24, 6, -1);

        for (int k = 0; k < 16; k++) run_frame({1'b0, 5'd0, 10'(k), 8'(k + 16)}, 24, 4, -1);
        for (int k = 0; k < 16; k++) run_frame({1'b1, 5'd0, 10'(k), 8'h00}, 24, 4, -1);

        for (int n = 0; n < 40; n++) begin
            ra = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(16, 1023)) : 10'($urandom_range(0, 15));
            fr = {1'($urandom), 5'($urandom), ra, 8'($urandom)};
            nb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 23)) : 24;
            run_frame(fr, nb, int'($urandom_range(4, 9)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
